// File: rtl/instr_fetch_if.sv
// Fetch-side buses: instruction-memory request/response channel and the
// instruction handshake toward decode.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr, instr, instr_valid,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr, instr_valid,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Multi-cycle RV32I fetch stage: one memory read per PC, instruction held for
// decode, misaligned-target halt and a delivered-instruction counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_next,
  input  logic                pc_update,
  instr_fetch_if.master       bus,
  output logic [31:0]         pc,
  output logic                fetch_fault,
  output logic [31:0]         fetch_count
);

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [2:0] state;

  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = (state == S_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      pc          <= RESET_PC;
      bus.instr   <= '0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_RESET: state <= S_REQ;
        S_REQ: begin
          if (bus.imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            bus.instr <= bus.imem_rsp_data;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (pc_update) begin
            pc <= pc_next;
            // A misaligned target halts fetch without touching memory.
            if (pc_next[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              state       <= S_FAULT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_RESET;
      endcase
    end
  end

endmodule
